// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler: arbitrates two colour requesters onto the RGB LED PWM pins.
// A granted colour is shown for max(dur,1)*TICK_DIV cycles, then DEFAULT_RGB.
// Optional build macro: RGB_PREEMPT_EN lets requester 0 preempt a requester 1 display.
module rgb_led_scheduler #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DUR_BITS    = 16,
  parameter int unsigned TICK_DIV    = 1024,
  parameter logic [23:0] DEFAULT_RGB = 24'h000010
) (
  input  logic                hw_clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [23:0]         req0_rgb,
  input  logic [DUR_BITS-1:0] req0_dur,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [23:0]         req1_rgb,
  input  logic [DUR_BITS-1:0] req1_dur,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned PS_W = $clog2(TICK_DIV);

  typedef enum logic {IDLE, SHOW} state_t;
  // Index 2 = red, 1 = green, 0 = blue.
  typedef logic [2:0][PWM_BITS-1:0] duty_t;

  function automatic duty_t rgb_to_duty(input logic [23:0] c);
    duty_t d;
    d[2] = PWM_BITS'(c[23:16]);
    d[1] = PWM_BITS'(c[15:8]);
    d[0] = PWM_BITS'(c[7:0]);
    return d;
  endfunction

  state_t              state, state_nxt;
  duty_t               shadow, shadow_nxt;
  duty_t               duty;
  logic [DUR_BITS-1:0] dur_cnt, dur_nxt;
  logic [PS_W-1:0]     presc, presc_nxt;
  logic                busy_nxt, owner_nxt;
  logic                presc_wrap, acc0, acc1;
  logic [DUR_BITS-1:0] sel_dur;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Next-state, handshake and display-timer logic.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    dur_nxt    = dur_cnt;
    presc_nxt  = presc;
    busy_nxt   = busy;
    owner_nxt  = owner;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sel_dur    = req0_dur;
    presc_wrap = (presc == PS_W'(TICK_DIV - 1));

    unique case (state)
      IDLE: begin
        req0_ready = 1'b1;
        req1_ready = !req0_valid;
        shadow_nxt = rgb_to_duty(DEFAULT_RGB);
      end
      SHOW: begin
`ifdef RGB_PREEMPT_EN
        req0_ready = owner;
`endif
        presc_nxt = presc_wrap ? '0 : presc + PS_W'(1);
        if (presc_wrap) begin
          dur_nxt = dur_cnt - DUR_BITS'(1);
          if (dur_cnt == DUR_BITS'(1)) begin
            state_nxt  = IDLE;
            busy_nxt   = 1'b0;
            shadow_nxt = rgb_to_duty(DEFAULT_RGB);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end

    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready & !acc0;

    // An accept (or preempt) reloads the whole display context.
    if (acc0 || acc1) begin
      sel_dur    = acc0 ? req0_dur : req1_dur;
      state_nxt  = SHOW;
      shadow_nxt = rgb_to_duty(acc0 ? req0_rgb : req1_rgb);
      dur_nxt    = (sel_dur == '0) ? DUR_BITS'(1) : sel_dur;
      presc_nxt  = '0;
      owner_nxt  = acc1;
      busy_nxt   = 1'b1;
    end
  end

  // Scheduler state register.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      dur_cnt <= '0;
      presc   <= '0;
      busy    <= 1'b0;
      owner   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      dur_cnt <= dur_nxt;
      presc   <= presc_nxt;
      busy    <= busy_nxt;
      owner   <= owner_nxt;
    end
  end

  // Free-running PWM; active duties swap only at period wrap to avoid glitches.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_r   <= 1'b0;
      pwm_g   <= 1'b0;
      pwm_b   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1) duty <= shadow;
      pwm_r <= (pwm_cnt < duty[2]);
      pwm_g <= (pwm_cnt < duty[1]);
      pwm_b <= (pwm_cnt < duty[0]);
    end
  end

endmodule
